reg_bus_move_sequencer: RTL and testbench

Sequences register-to-register moves across the CPU's shared tristate data bus. It drives the per-register chip-selects and clock-enables of the bus-attached register flip-flop array, which sits directly downstream. On each accepted request it enables exactly one source register onto the bus, loads the destination register from the bus, then releases the bus. It also keeps a snapshot of the moved value for debug and flags.

---
 rtl/reg_bus_move_sequencer_pkg.sv | 23 ++
 rtl/reg_bus_move_sequencer_reg_index_decoder.sv | 27 ++
 rtl/reg_bus_move_sequencer.sv | 135 +++++++++++++
 tb/tb_reg_bus_move_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_move_sequencer_pkg.sv
// Shared definitions for the register bus move sequencer: default sizes,
// the move FSM state encoding and a small index range helper.
package reg_bus_move_sequencer_pkg;

    // Default data bus width and number of bus-attached registers
    localparam int DefNrOfBits    = 8;
    localparam int DefNrOfRegs    = 4;
    localparam int DefRegSelBits  = 2;

    // Move sequence phases; the numeric encoding is shared with the rest of the CPU
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        LOAD    = 2'd2,
        RELEASE = 2'd3
    } moveState_e;

    // True when a register index addresses a register that actually exists
    function automatic logic indexInRange(input int unsigned idx, input int unsigned count);
        return idx < count;
    endfunction

endpackage

// File: rtl/reg_bus_move_sequencer_reg_index_decoder.sv
// Parameterised register index to one-hot decoder. The active-low variant
// produces chip-select style vectors (selected bit 0, others 1), the
// active-high variant produces clock-enable style vectors. Indices that do
// not address an existing register select nothing.
module reg_index_decoder #(
    parameter int NrOfRegs   = 4,
    parameter int RegSelBits = 2,
    parameter bit ActiveLow  = 1'b0
) (
    input  logic [RegSelBits-1:0] index_i,
    input  logic                  enable_i,
    output logic [NrOfRegs-1:0]   sel_o
);

    // Compare the index against every register position and apply polarity
    always_comb begin
        sel_o = '0;
        for (int unsigned i = 0; i < NrOfRegs; i++) begin
            if (enable_i && (32'(index_i) == i)) begin
                sel_o[i] = ~ActiveLow;
            end else begin
                sel_o[i] = ActiveLow;
            end
        end
    end

endmodule

// File: rtl/reg_bus_move_sequencer.sv
// Register-to-register move sequencer for the shared tristate data bus.
// Each accepted request enables one source register onto the bus, loads the
// destination register from the bus and then releases the bus again. All
// outputs are registered so the downstream register array sees clean
// chip-selects and clock-enables with no path from the request inputs.
module reg_bus_move_sequencer
    import reg_bus_move_sequencer_pkg::*;
#(
    parameter int NrOfBits   = DefNrOfBits,
    parameter int NrOfRegs   = DefNrOfRegs,
    parameter int RegSelBits = DefRegSelBits
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  tick_i,
    input  logic                  req_i,
    input  logic [RegSelBits-1:0] src_i,
    input  logic [RegSelBits-1:0] dst_i,
    input  logic [NrOfBits-1:0]   bus_in_i,
    output logic [NrOfRegs-1:0]   reg_cs_o,
    output logic [NrOfRegs-1:0]   reg_ce_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [NrOfBits-1:0]   last_value_o
);

    moveState_e            state_q;
    logic [RegSelBits-1:0] src_q;
    logic [RegSelBits-1:0] dst_q;
    logic [NrOfRegs-1:0]   reg_cs_q;
    logic [NrOfRegs-1:0]   reg_ce_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [NrOfBits-1:0]   last_value_q;

    logic                  reqValid;
    logic [RegSelBits-1:0] csIndex;
    logic [NrOfRegs-1:0]   reg_cs_d;
    logic [NrOfRegs-1:0]   reg_ce_d;

    // A request is only legal when both indices address existing registers
    always_comb begin
        reqValid = indexInRange(32'(src_i), NrOfRegs) && indexInRange(32'(dst_i), NrOfRegs);
    end

    // In IDLE the chip-select is decoded from the incoming source so the
    // DRIVE pattern is ready on the same edge that latches the indices
    always_comb begin
        csIndex = (state_q == IDLE) ? src_i : src_q;
    end

    reg_index_decoder #(
        .NrOfRegs   (NrOfRegs),
        .RegSelBits (RegSelBits),
        .ActiveLow  (1'b1)
    ) u_csDecoder (
        .index_i  (csIndex),
        .enable_i (1'b1),
        .sel_o    (reg_cs_d)
    );

    reg_index_decoder #(
        .NrOfRegs   (NrOfRegs),
        .RegSelBits (RegSelBits),
        .ActiveLow  (1'b0)
    ) u_ceDecoder (
        .index_i  (dst_q),
        .enable_i (1'b1),
        .sel_o    (reg_ce_d)
    );

    // Move FSM with registered bus controls; only Tick-qualified edges advance it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            reg_cs_q     <= '1;
            reg_ce_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            last_value_q <= '0;
        end else if (tick_i) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        if (reqValid) begin
                            src_q    <= src_i;
                            dst_q    <= dst_i;
                            reg_cs_q <= reg_cs_d;
                            busy_q   <= 1'b1;
                            state_q  <= DRIVE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    reg_ce_q <= reg_ce_d;
                    state_q  <= LOAD;
                end
                LOAD: begin
                    last_value_q <= bus_in_i;
                    reg_cs_q     <= '1;
                    reg_ce_q     <= '0;
                    done_q       <= 1'b1;
                    state_q      <= RELEASE;
                end
                RELEASE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    reg_cs_q <= '1;
                    reg_ce_q <= '0;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign reg_cs_o     = reg_cs_q;
    assign reg_ce_o     = reg_ce_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign last_value_o = last_value_q;

endmodule

// File: tb/tb_reg_bus_move_sequencer.sv
// Bench for the register bus move sequencer. A small behavioural register
// array sits on the bus; a script-based reference model predicts every
// Tick-qualified step of a move as a queue of expected output snapshots.
module tb_reg_bus_move_sequencer;

    localparam int NB = 8;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tick;
    logic          req;
    logic [1:0]    src;
    logic [1:0]    dst;
    logic [NB-1:0] busIn;
    logic [NR-1:0] cs;
    logic [NR-1:0] ce;
    logic          busy;
    logic          done;
    logic          err;
    logic [NB-1:0] lastVal;

    logic          req3;
    logic [1:0]    src3;
    logic [1:0]    dst3;
    logic [NB-1:0] busIn3;
    logic [2:0]    cs3;
    logic [2:0]    ce3;
    logic          busy3;
    logic          done3;
    logic          err3;
    logic [NB-1:0] lastVal3;

    int checkCount = 0;
    int passCount  = 0;

    always #5 clk = ~clk;

    reg_bus_move_sequencer #(.NrOfBits(NB), .NrOfRegs(NR), .RegSelBits(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .req_i(req), .src_i(src), .dst_i(dst),
        .bus_in_i(busIn), .reg_cs_o(cs), .reg_ce_o(ce), .busy_o(busy), .done_o(done),
        .err_o(err), .last_value_o(lastVal)
    );

    reg_bus_move_sequencer #(.NrOfBits(NB), .NrOfRegs(3), .RegSelBits(2)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .req_i(req3), .src_i(src3), .dst_i(dst3),
        .bus_in_i(busIn3), .reg_cs_o(cs3), .reg_ce_o(ce3), .busy_o(busy3), .done_o(done3),
        .err_o(err3), .last_value_o(lastVal3)
    );

    // Bus-attached register array loaded by the sequencer's clock-enables
    logic [NB-1:0] regs [NR] = '{8'h10, 8'h21, 8'h32, 8'h43};
    int            loadCount [NR] = '{default: 0};
    logic          preloadEn   = 1'b0;
    logic          clearCounts = 1'b0;
    logic [1:0]    preloadIdx  = '0;
    logic [NB-1:0] preloadVal  = '0;

    always @(posedge clk) begin
        if (clearCounts) begin
            for (int i = 0; i < NR; i++) loadCount[i] <= 0;
        end
        if (preloadEn) begin
            regs[preloadIdx] <= preloadVal;
        end else if (tick) begin
            for (int i = 0; i < NR; i++) begin
                if (ce[i]) begin
                    regs[i]      <= busIn;
                    loadCount[i] <= loadCount[i] + 1;
                end
            end
        end
    end

    // Resolved bus: the register whose chip-select is low drives it
    always_comb begin
        busIn = 8'h00;
        for (int i = 0; i < NR; i++) begin
            if (!cs[i]) busIn = regs[i];
        end
    end

    // Reference model: a move is a fixed script of four Tick steps
    typedef struct {
        logic [NR-1:0] cs;
        logic [NR-1:0] ce;
        logic          busy;
        logic          done;
        logic          err;
        logic          capture;
    } expRec_t;

    expRec_t       scriptQ [$];
    expRec_t       cur;
    logic [NB-1:0] expLast;

    function automatic expRec_t mkRec(logic [NR-1:0] c, logic [NR-1:0] e, logic b,
                                      logic d, logic er, logic cap);
        expRec_t r;
        r.cs = c; r.ce = e; r.busy = b; r.done = d; r.err = er; r.capture = cap;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [NR-1:0] one;
        logic [NR-1:0] srcSel;
        logic [NR-1:0] dstSel;
        one = 4'b0001;
        if (!rst_n) begin
            scriptQ.delete();
            cur     = mkRec(4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
            expLast = '0;
        end else if (tick) begin
            if (cur.capture) expLast = busIn;
            if (scriptQ.size() == 0 && req && int'(src) < NR && int'(dst) < NR) begin
                srcSel = one << src;
                dstSel = one << dst;
                scriptQ.push_back(mkRec(~srcSel, 4'h0,   1'b1, 1'b0, 1'b0, 1'b0));
                scriptQ.push_back(mkRec(~srcSel, dstSel, 1'b1, 1'b0, 1'b0, 1'b1));
                scriptQ.push_back(mkRec(4'hF,    4'h0,   1'b1, 1'b1, 1'b0, 1'b0));
                scriptQ.push_back(mkRec(4'hF,    4'h0,   1'b0, 1'b0, 1'b0, 1'b0));
            end
            if (scriptQ.size() != 0) cur = scriptQ.pop_front();
            else                     cur = mkRec(4'hF, 4'h0, 1'b0, 1'b0, req, 1'b0);
        end
    end

    // Single comparison with pass/fail bookkeeping
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic checkCycle();
        checkOutput("reg_cs", 32'(cs), 32'(cur.cs));
        checkOutput("reg_ce", 32'(ce), 32'(cur.ce));
        checkOutput("busy", 32'(busy), 32'(cur.busy));
        checkOutput("done", 32'(done), 32'(cur.done));
        checkOutput("err", 32'(err), 32'(cur.err));
        checkOutput("last_value", 32'(lastVal), 32'(expLast));
        checkOutput("one_cs_low", 32'($countones(~cs) <= 1), 32'd1);
        checkOutput("ce_onehot_with_cs", 32'((ce == 0) || ($onehot(ce) && cs != 4'hF)), 32'd1);
    endtask

    // Drive one cycle of inputs at a falling edge, then check after the next edge
    task automatic applyStimulus(input logic t, input logic r, input logic [1:0] s, input logic [1:0] d);
        tick = t; req = r; src = s; dst = d;
        @(posedge clk);
        @(negedge clk);
        checkCycle();
    endtask

    task automatic preloadReg(input logic [1:0] idx, input logic [NB-1:0] val);
        preloadEn = 1'b1; clearCounts = 1'b1; preloadIdx = idx; preloadVal = val;
        applyStimulus(1'b0, 1'b0, 2'd0, 2'd0);
        preloadEn = 1'b0; clearCounts = 1'b0;
    endtask

    typedef struct {
        logic [1:0]    src;
        logic [1:0]    dst;
        logic [NB-1:0] val;
        int            period;
        logic [NR-1:0] expCs;
        logic [NR-1:0] expCe;
    } moveVec_t;

    moveVec_t vecs [5];

    initial begin
        int drives;
        int drivesAfterRelease;
        logic prevAllOnes;
        int doneRises;
        logic prevDone;

        vecs[0] = '{src: 2'd1, dst: 2'd3, val: 8'hA5, period: 1, expCs: 4'b1101, expCe: 4'b1000};
        vecs[1] = '{src: 2'd1, dst: 2'd3, val: 8'hA5, period: 4, expCs: 4'b1101, expCe: 4'b1000};
        vecs[2] = '{src: 2'd2, dst: 2'd2, val: 8'h3C, period: 1, expCs: 4'b1011, expCe: 4'b0100};
        vecs[3] = '{src: 2'd0, dst: 2'd1, val: 8'h5A, period: 2, expCs: 4'b1110, expCe: 4'b0010};
        vecs[4] = '{src: 2'd3, dst: 2'd0, val: 8'hC3, period: 3, expCs: 4'b0111, expCe: 4'b0001};

        rst_n = 1'b1; tick = 1'b0; req = 1'b0; src = '0; dst = '0;
        req3 = 1'b0; src3 = '0; dst3 = '0; busIn3 = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_cs", 32'(cs), 32'hF);
        checkOutput("rst_ce", 32'(ce), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_err", 32'(err), 32'h0);
        checkOutput("rst_last", 32'(lastVal), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd0);

        // Table-driven single moves with different Tick rates
        foreach (vecs[v]) begin
            preloadReg(vecs[v].src, vecs[v].val);
            doneRises = 0;
            prevDone  = done;
            for (int k = 0; k <= 3 * vecs[v].period; k++) begin
                applyStimulus((k % vecs[v].period) == 0, k == 0, vecs[v].src, vecs[v].dst);
                if (k == 0) checkOutput("tbl_drive_cs", 32'(cs), 32'(vecs[v].expCs));
                if (k == vecs[v].period) checkOutput("tbl_load_ce", 32'(ce), 32'(vecs[v].expCe));
                if (done && !prevDone) doneRises++;
                prevDone = done;
            end
            checkOutput("tbl_dst_value", 32'(regs[vecs[v].dst]), 32'(vecs[v].val));
            checkOutput("tbl_load_count", 32'(loadCount[vecs[v].dst]), 32'd1);
            checkOutput("tbl_last_value", 32'(lastVal), 32'(vecs[v].val));
            checkOutput("tbl_done_pulses", 32'(doneRises), 32'd1);
            checkOutput("tbl_idle_busy", 32'(busy), 32'd0);
        end

        // req held high: moves restart only after a released-bus cycle
        preloadReg(2'd0, 8'h11);
        drives = 0; drivesAfterRelease = 0; prevAllOnes = (cs == 4'hF);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 1'b1, 2'd0, 2'd1);
            if (cs != 4'hF && prevAllOnes) begin
                drives++;
                drivesAfterRelease++;
            end
            prevAllOnes = (cs == 4'hF);
        end
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 2'd0, 2'd0);
        checkOutput("b2b_drive_count", 32'(drives), 32'd3);
        checkOutput("b2b_released_between", 32'(drivesAfterRelease), 32'(drives));
        checkOutput("b2b_dst_value", 32'(regs[1]), 32'h11);

        // Asynchronous reset in the middle of a load
        preloadReg(2'd1, 8'h77);
        preloadReg(2'd2, 8'h22);
        applyStimulus(1'b1, 1'b1, 2'd1, 2'd2);
        applyStimulus(1'b1, 1'b0, 2'd1, 2'd2);
        checkOutput("midload_ce", 32'(ce), 32'h4);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midload_rst_cs", 32'(cs), 32'hF);
        checkOutput("midload_rst_ce", 32'(ce), 32'h0);
        checkOutput("midload_rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd0);
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd0);
        checkOutput("midload_dst_kept", 32'(regs[2]), 32'h22);
        checkOutput("midload_no_load", 32'(loadCount[2]), 32'd0);

        // Out-of-range source on the three-register instance
        req3 = 1'b1; src3 = 2'd3; dst3 = 2'd0;
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd0);
        req3 = 1'b0;
        checkOutput("range_err", 32'(err3), 32'd1);
        checkOutput("range_busy", 32'(busy3), 32'd0);
        checkOutput("range_cs", 32'(cs3), 32'h7);
        checkOutput("range_ce", 32'(ce3), 32'h0);
        applyStimulus(1'b1, 1'b0, 2'd0, 2'd0);
        checkOutput("range_err_clear", 32'(err3), 32'd0);
        checkOutput("range_cs_after", 32'(cs3), 32'h7);

        // Randomised traffic against the reference model
        for (int k = 0; k < 300; k++) begin
            applyStimulus(($urandom % 3) != 0, $urandom % 2 == 0, 2'($urandom % 4), 2'($urandom % 4));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
